// File: rtl/modmul_pkg.sv
// Shared constants, state encoding and fill values for the modmul stream front/back end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package modmul_pkg;

  localparam int WORD_W = 32;
  localparam int OP_W   = 256;
  localparam int NWORDS = OP_W / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  // Index of the most significant word of an operand
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  // Result substituted when the core never reports completion
  localparam logic [OP_W-1:0] TIMEOUT_FILL = '1;

  typedef enum logic [2:0] {
    LOAD_X,
    LOAD_Y,
    START,
    WAIT,
    DRAIN
  } state_t;

endpackage

// File: rtl/modmul_stream_io_if.sv
// Word stream bundle: operand words in, result words out, each under valid/ready.
// Latency: n/a (wires only).
// Backpressure: in_ready stalls the producer, out_ready stalls the result stream.
interface modmul_stream_io_if;

  logic                          in_valid;
  logic                          in_ready;
  logic [modmul_pkg::WORD_W-1:0] in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [modmul_pkg::WORD_W-1:0] out_data;
  logic                          out_last;

  // Host side: produces operand words, consumes result words
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Block side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/modmul_word_shift.sv
// Word-addressable OP_W register: write one word at an index, or load all bits at once; read one word at an index.
// Latency: writes visible the cycle after; read is combinational.
// Backpressure: none (caller qualifies wr_en/ld_en).
module modmul_word_shift
  import modmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              ld_en,
  input  logic [OP_W-1:0]   ld_data,
  input  logic [CNT_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data,
  output logic [OP_W-1:0]   value
);

  logic [OP_W-1:0] store;

  // Full load takes priority over a single-word write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store <= '0;
    end else if (ld_en) begin
      store <= ld_data;
    end else if (wr_en) begin
      store[wr_idx*WORD_W +: WORD_W] <= wr_data;
    end
  end

  assign rd_data = store[rd_idx*WORD_W +: WORD_W];
  assign value   = store;

endmodule

// File: rtl/modmul_stream_io.sv
// Word-serial front/back end for the 256-bit modular multiplier: gathers X then Y, pulses start, streams Q out.
// Latency: last Y word to mm_start 1 cycle; mm_done rising edge to first out_valid 1 cycle.
// Backpressure: in_ready only in load states; out_valid/out_data/out_last hold while out_ready is low.
// Optional watchdog: define MODMUL_TIMEOUT_EN to bound WAIT to TIMEOUT_CYCLES and raise a sticky err.
module modmul_stream_io
  import modmul_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  modmul_stream_io_if.slave   sio,
  output logic                busy,
  output logic                err,
  output logic                mm_start,
  output logic [OP_W-1:0]     mm_X,
  output logic [OP_W-1:0]     mm_Y,
  input  logic [OP_W-1:0]     mm_Q,
  input  logic                mm_done
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             done_q;
  logic             done_rise;
  logic             tmo_hit;
  logic             hs_in;
  logic             hs_out;
  logic             q_load;
  logic [WORD_W-1:0] q_word;
  logic [WORD_W-1:0] x_rd_unused;
  logic [WORD_W-1:0] y_rd_unused;
  logic [OP_W-1:0]   q_all_unused;

  assign done_rise = mm_done & ~done_q;
  assign hs_in     = sio.in_valid & sio.in_ready;
  assign hs_out    = sio.out_valid & sio.out_ready;
  assign q_load    = (state == WAIT) && (done_rise || tmo_hit);

  // run keeps in_ready low while rst is asserted and releases it one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      run    <= 1'b1;
      done_q <= mm_done;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_X;
    else     state <= state_nx;
  end

  // Next-state: load X, load Y, kick the core, wait for its done edge, drain the result
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD_X:  if (hs_in && cnt == LAST_IDX) state_nx = LOAD_Y;
      LOAD_Y:  if (hs_in && cnt == LAST_IDX) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (done_rise || tmo_hit) state_nx = DRAIN;
      DRAIN:   if (hs_out && cnt == LAST_IDX) state_nx = LOAD_X;
      default: state_nx = LOAD_X;
    endcase
  end

  // Word index shared by the load and drain phases; zeroed between them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case (state)
        LOAD_X, LOAD_Y: if (hs_in)  cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        DRAIN:          if (hs_out) cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        default:        cnt <= '0;
      endcase
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    sio.in_ready  = run && (state == LOAD_X || state == LOAD_Y);
    mm_start      = (state == START);
    sio.out_valid = (state == DRAIN);
    sio.out_last  = (state == DRAIN) && (cnt == LAST_IDX);
    sio.out_data  = (state == DRAIN) ? q_word : '0;
    busy          = !(state == LOAD_X && cnt == '0);
  end

  modmul_word_shift u_x (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hs_in && state == LOAD_X),
    .wr_idx  (cnt),
    .wr_data (sio.in_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .rd_idx  ('0),
    .rd_data (x_rd_unused),
    .value   (mm_X)
  );

  modmul_word_shift u_y (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hs_in && state == LOAD_Y),
    .wr_idx  (cnt),
    .wr_data (sio.in_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .rd_idx  ('0),
    .rd_data (y_rd_unused),
    .value   (mm_Y)
  );

  // A genuine done edge wins over a watchdog expiry in the same cycle
  modmul_word_shift u_q (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (1'b0),
    .wr_idx  ('0),
    .wr_data ('0),
    .ld_en   (q_load),
    .ld_data (done_rise ? mm_Q : TIMEOUT_FILL),
    .rd_idx  (cnt),
    .rd_data (q_word),
    .value   (q_all_unused)
  );

`ifdef MODMUL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // Counts WAIT cycles; held at zero elsewhere so it restarts on every WAIT entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tmo_cnt <= '0;
    else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    else                    tmo_cnt <= '0;
  end

  assign tmo_hit = (state == WAIT) && !done_rise &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Sticky error, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (tmo_hit) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  localparam int TMO_UNUSED = TIMEOUT_CYCLES;

  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: doc/modmul_stream_io.md
Name: modmul_stream_io

Overview:
- Word-serial front/back end for the 256-bit modular multiplier core (clk, rst, start, X, Y, Q, done).
- Collects X then Y as 32-bit words from an upstream valid/ready stream and presents them in parallel to the core.
- Issues a one-cycle start, waits for done, latches Q, then streams Q out as 32-bit words under valid/ready with a last flag.

Parameters:
- WORD_W, 32, stream word width in bits.
- OP_W, 256, operand/result width; must be an integer multiple of WORD_W.
- NWORDS, OP_W/WORD_W (8), derived localparam; words per operand.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only when MODMUL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  WORD_W  operand word; LS word first, X words 0..7, then Y words 0..7.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts a word.
- out_data  out  WORD_W  Q word, LS word first.
- out_last  out  1  high with the final (MS) Q word.
- busy  out  1  high in any state other than LOAD_X with a zero word count.
- err  out  1  sticky watchdog error; tied 0 without the macro.
- mm_start  out  1  start pulse to the multiplier core.
- mm_X  out  OP_W  operand X to the core.
- mm_Y  out  OP_W  operand Y to the core.
- mm_Q  in  OP_W  core result.
- mm_done  in  1  core completion, level or pulse.

Behaviour:
- Reset (async, rst=1) values:
  - State is LOAD_X; word counter is 0.
  - in_ready=0 while rst is high, then 1 from the first cycle after release.
  - out_valid=0, out_last=0, out_data=0, mm_start=0, mm_X=0, mm_Y=0, busy=0, err=0.
  - The Q latch is 0.
- LOAD_X:
  - in_ready=1; each in_valid&in_ready handshake writes in_data into mm_X[cnt*WORD_W +: WORD_W] and increments cnt.
  - At cnt=NWORDS-1 with a handshake, go to LOAD_Y with cnt=0.
- LOAD_Y: same as LOAD_X but fills mm_Y. Its final handshake goes to START.
- START:
  - in_ready=0; mm_start=1 for exactly one cycle; go to WAIT.
  - mm_X and mm_Y stay stable from the end of LOAD_Y until the block returns to LOAD_X.
- WAIT:
  - in_ready=0; detect the rising edge of mm_done (registered previous value).
  - On the edge, latch mm_Q into the Q register, set cnt=0, and go to DRAIN.
  - A done level already high when WAIT is entered does not count; only a 0->1 transition qualifies.
- DRAIN:
  - out_valid=1; out_data = Qreg[cnt*WORD_W +: WORD_W]; out_last = (cnt==NWORDS-1).
  - out_valid, out_data and out_last hold steady while out_ready=0.
  - Each out_valid&out_ready handshake increments cnt.
  - The handshake on the last word returns to LOAD_X with cnt=0 and out_valid=0 in the next cycle.
- Latency:
  - Last Y handshake to mm_start is 1 cycle.
  - mm_done rising edge to first out_valid is 1 cycle.
- Back-to-back: a new X load begins the cycle after the last Q word is taken. There is no overlap between the load and drain phases.
- in_valid while in_ready=0 is ignored, with no side effects. in_data is don't-care when in_valid=0.
- Asserting rst mid-operation aborts the transaction immediately. Partially loaded operands and the Q latch are cleared, and outputs return to their reset values.
- mm_done during LOAD_X, LOAD_Y, START or DRAIN is ignored. The edge detector still tracks it.

Optional Feature:
- Macro MODMUL_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without a done edge, set err=1 (sticky until rst) and go to DRAIN with the Q latch forced to all-ones.
  - The host therefore still receives 8 words, ending with out_last.
- Not defined: no counter is built; err is constant 0; WAIT holds indefinitely.

Decomposition:
- Shared package modmul_pkg holds:
  - WORD_W, OP_W and NWORDS constants.
  - The state enum (LOAD_X, LOAD_Y, START, WAIT, DRAIN).
  - The all-ones timeout fill constant.
- One natural sub-module: modmul_word_shift, a word-indexed OP_W register with load-word-at-index and read-word-at-index. It is instantiated for X, Y and Q.

Test Plan:
- Reset mid-LOAD_Y (after 3 Y words): rst pulse -> all outputs zero and state LOAD_X. A fresh 16-word load then starts normally.
- Load X words 0x00000001,0,0,0,0,0,0,0 and Y words 0x00000002,0,...,0 with in_valid held high:
  - mm_X==1 and mm_Y==2; mm_start is exactly 1 cycle, 1 cycle after the 16th handshake.
  - A core model returning Q=2 with done after 10 cycles -> out words 2,0,0,0,0,0,0,0, with out_last only on the 8th.
- Gapped in_valid (every other cycle) and random out_ready stalls:
  - Operand assembly is unchanged.
  - out_data, out_valid and out_last hold steady across each stall.
  - Exactly 8 output handshakes occur.
- X=0x9a1de644815ef6d13b8faa1837f8a88b17fc695a07a0ca6e0822e8f36c031199 streamed LS word first (0x6c031199 first) -> mm_X is bit-exact.
- mm_done held high from the START cycle, then dropped and raised 5 cycles later -> only the later rising edge triggers DRAIN.
- With MODMUL_TIMEOUT_EN and TIMEOUT_CYCLES=16, mm_done never asserted:
  - err=1 exactly 16 cycles after WAIT entry.
  - 8 words of 0xFFFFFFFF are output, with out_last on the 8th.
  - err stays high until rst.
